// File: rtl/bias_fetch_sched.sv
// Credit-based bias ROM prefetcher feeding the MAC array over valid/ready.
// Define BIAS_FETCH_PERF_EN to add the o_stall_cnt starvation counter.
module bias_fetch_sched #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_num_words,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rom_cs,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_dout,
    output logic              o_bias_vld,
    output logic [DATA_W-1:0] o_bias,
    input  logic              i_bias_rdy
`ifdef BIAS_FETCH_PERF_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W:0] DEPTH_C = (FCNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base;
    logic [CNT_W-1:0]    num_words;
    logic [CNT_W-1:0]    issue_cnt;
    logic [CNT_W-1:0]    pop_cnt;
    logic                inflight;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [FCNT_W-1:0]   fifo_count;
    logic [DATA_W-1:0]   last_bias;

    logic [FCNT_W:0]     credit_used;
    logic                issue;
    logic                push;
    logic                pop;

    // Words stored plus the one still coming back from the ROM must leave room.
    assign credit_used = {1'b0, fifo_count} + {{FCNT_W{1'b0}}, inflight};
    assign issue       = (state == FETCH) && (issue_cnt < num_words) && (credit_used < DEPTH_C);
    assign push        = inflight;
    assign pop         = o_bias_vld && i_bias_rdy;

    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_rom_cs    = issue;
    assign o_rom_addr  = issue ? (base + ADDR_W'(issue_cnt)) : '0;
    assign o_bias_vld  = (fifo_count != '0);
    assign o_bias      = o_bias_vld ? mem[rd_ptr] : last_bias;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            num_words <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base      <= i_base_addr;
                        num_words <= i_num_words;
                        issue_cnt <= '0;
                        pop_cnt   <= '0;
                        state     <= (i_num_words == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (pop) begin
                        pop_cnt <= pop_cnt + CNT_W'(1);
                        if ((pop_cnt + CNT_W'(1)) == num_words) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= i_rom_dout;
        end
    end

    // last_bias keeps o_bias stable while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_bias  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_bias <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef BIAS_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stall_cnt <= '0;
        end else if ((state == IDLE) && i_start) begin
            o_stall_cnt <= '0;
        end else if (o_busy && i_bias_rdy && !o_bias_vld && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/bias_fetch_sched.md
Name: bias_fetch_sched

Overview:
Sequences reads from the 128x64 bias ROM for one layer. It prefetches a programmed run of bias words into a small FIFO and hands them to the MAC array over a valid/ready handshake. It sits between the layer controller, which issues start, base address and word count, and the array's bias-consume port. It replaces free-running address counting with credit-based issue, so ROM reads never overrun the consumer.

Parameters:
ADDR_W, 7, bias ROM address width (128 entries)
DATA_W, 64, bias word width
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2
CNT_W, 8, width of word-count input

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_start  input  1  start pulse; sampled only in IDLE
i_base_addr  input  ADDR_W  first ROM address of the run, captured on accepted start
i_num_words  input  CNT_W  words in the run, captured on accepted start
o_busy  output  1  high from accepted start until the done cycle, inclusive
o_done  output  1  one-cycle pulse when the last word is popped by the consumer
o_rom_cs  output  1  ROM enable; high exactly in cycles that issue a read
o_rom_addr  output  ADDR_W  ROM read address
i_rom_dout  input  DATA_W  ROM data, valid 1 cycle after the cs/addr cycle
o_bias_vld  output  1  FIFO head valid
o_bias  output  DATA_W  FIFO head data
i_bias_rdy  input  1  consumer ready; pop when o_bias_vld & i_bias_rdy

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst. Reset clears all state: FSM to IDLE, FIFO empty, in-flight flag 0, counters 0.
- Reset values of outputs: o_busy=0, o_done=0, o_rom_cs=0, o_rom_addr=0, o_bias_vld=0, o_bias=0.
- FSM states:
  - IDLE: on i_start, capture base and count, set issue_cnt=pop_cnt=0. If count==0, go to DONE. Otherwise go to FETCH.
  - FETCH: issue reads under the credit rule. When pop_cnt reaches count, go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=1. Next state is IDLE.
- Credit rule: issue in a cycle iff state==FETCH, issue_cnt<count, and (fifo_count + inflight) < FIFO_DEPTH.
  - fifo_count is the registered count before this cycle's push/pop.
  - inflight is 1 if a read was issued last cycle.
  - An issue drives o_rom_cs=1 and o_rom_addr=(base+issue_cnt) mod 2^ADDR_W, then increments issue_cnt.
- Address wrap: base=126, count=4 reads addresses 126,127,0,1.
- Read latency: i_rom_dout is pushed into the FIFO in the cycle after the issue (inflight=1). A push can never hit a full FIFO, by the credit rule.
- First-word latency: the start cycle is T0. The first issue is at T1, the push at T2, and o_bias_vld=1 from T3.
- Sustained throughput: 1 word/cycle when i_bias_rdy is held high.
- Simultaneous push and pop: fifo_count is unchanged and both take effect.
- Pop on an empty FIFO is ignored.
- o_bias shows the FIFO head whenever o_bias_vld=1. It holds its last value otherwise; after reset it is 0.
- Consumer stall: the FIFO fills to FIFO_DEPTH and issue stops. Issue resumes the cycle after a pop frees credit. No word is ever dropped or duplicated.
- i_start while o_busy=1 is ignored, with no effect on the current run.
- count==0: o_rom_cs never asserts. o_busy=1 and o_done=1 in the cycle after start, then IDLE.
- pop_cnt counts handshakes. o_done asserts the cycle after the handshake that makes pop_cnt==count.
- Reset mid-run drops the pending ROM data. The FIFO is emptied, o_done is not pulsed, and a new start is accepted the cycle after rst deasserts.

Optional Feature:
Macro BIAS_FETCH_PERF_EN.
- Defined: adds output o_stall_cnt [15:0]. It counts cycles with o_busy=1, i_bias_rdy=1 and o_bias_vld=0 (starvation). It saturates at 16'hFFFF, clears on accepted start and on rst, and holds after DONE until the next start.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- rst, then start base=0x10 count=3, rdy=1 -> o_rom_addr 0x10,0x11,0x12 on T1..T3. o_bias matches ROM[0x10..0x12] on T3..T5. o_done at T6. o_busy high T1..T6.
- Start base=0x7E count=4, rdy=1 -> reads 0x7E,0x7F,0x00,0x01 in order. 4 pops, then one o_done pulse.
- Start base=0 count=10, rdy=0 for 20 cycles -> exactly 4 o_rom_cs pulses and FIFO full. Then rdy=1 -> 10 words in order, no gaps after the first, o_done once.
- Start count=0 -> o_rom_cs never high. o_busy=o_done=1 on T1, then IDLE. A second i_start mid-run (count=8) is ignored and exactly 8 words are delivered.
- rst asserted mid-run after 2 of 6 pops -> all outputs at reset values next cycle, no o_done. A new start base=0x20 count=2 delivers ROM[0x20],ROM[0x21].
- With BIAS_FETCH_PERF_EN: count=3, rdy=1 throughout -> o_stall_cnt=3 (T1, T2 starvation, plus the DONE cycle T6) after DONE, then cleared to 0 on the next start.
